// File: rtl/i2c_byte_master.sv
// Single-byte I2C write master: optional START, 8 data bits, ACK sample, optional STOP.
// Define I2C_CLK_STRETCH_EN to let a slave stretch SCL by holding it low.
module i2c_byte_master #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic [7:0] cmd_data,
    output logic       done,
    output logic       nack,
    output logic       busy,
    inout  wire        scl,
    inout  wire        sda
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_ACK,
        S_STOP,
        S_HOLD
    } state_t;

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    state_t      r_state, w_stateNext;
    logic [1:0]  r_quarter, w_quarterNext;
    logic [2:0]  r_bitIdx, w_bitIdxNext;
    logic [7:0]  r_data, w_dataNext;
    logic        r_stop, w_stopNext;
    logic        r_fromHold, w_fromHoldNext;
    logic [15:0] r_div, w_divNext;
    logic        r_done, w_doneNext;
    logic        r_nack, w_nackNext;
    logic        r_ackSample, w_ackSampleNext;
    logic [1:0]  r_sdaSync;

    logic w_busy;
    logic w_accept;
    logic w_stretch;
    logic w_tick;
    logic w_sclLow;
    logic w_sdaLow;

    assign w_busy    = !(r_state == S_IDLE || r_state == S_HOLD);
    assign w_accept  = cmd_valid && !w_busy;
    assign w_tick    = w_busy && (r_div == DIV_LAST) && !w_stretch;

    assign cmd_ready = !w_busy;
    assign busy      = w_busy;
    assign done      = r_done;
    assign nack      = r_nack;

    assign scl = w_sclLow ? 1'b0 : 1'bz;
    assign sda = w_sdaLow ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sdaSync <= 2'b11;
        end else begin
            r_sdaSync <= {r_sdaSync[0], sda};
        end
    end

`ifdef I2C_CLK_STRETCH_EN
    logic [1:0] r_sclSync;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sclSync <= 2'b11;
        end else begin
            r_sclSync <= {r_sclSync[0], scl};
        end
    end

    // Only the end of q1 waits for SCL, so synchronizer lag after release never stretches.
    assign w_stretch = w_busy && (r_quarter == 2'd1) && !w_sclLow && !r_sclSync[1];
`else
    assign w_stretch = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_quarter   <= 2'd0;
            r_bitIdx    <= 3'd7;
            r_data      <= 8'h00;
            r_stop      <= 1'b0;
            r_fromHold  <= 1'b0;
            r_div       <= 16'd0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
            r_ackSample <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_quarter   <= w_quarterNext;
            r_bitIdx    <= w_bitIdxNext;
            r_data      <= w_dataNext;
            r_stop      <= w_stopNext;
            r_fromHold  <= w_fromHoldNext;
            r_div       <= w_divNext;
            r_done      <= w_doneNext;
            r_nack      <= w_nackNext;
            r_ackSample <= w_ackSampleNext;
        end
    end

    // Quarters advance on the divider tick; done and the latched ACK bit leave together.
    always_comb begin
        w_stateNext     = r_state;
        w_quarterNext   = r_quarter;
        w_bitIdxNext    = r_bitIdx;
        w_dataNext      = r_data;
        w_stopNext      = r_stop;
        w_fromHoldNext  = r_fromHold;
        w_divNext       = r_div;
        w_doneNext      = 1'b0;
        w_nackNext      = r_nack;
        w_ackSampleNext = r_ackSample;

        if (w_accept) begin
            w_divNext = 16'd0;
        end else if (w_busy) begin
            if (r_div != DIV_LAST) begin
                w_divNext = r_div + 16'd1;
            end else if (!w_stretch) begin
                w_divNext = 16'd0;
            end
        end

        if (w_tick) begin
            w_quarterNext = r_quarter + 2'd1;
        end

        case (r_state)
            S_IDLE, S_HOLD: begin
                if (w_accept) begin
                    w_dataNext     = cmd_data;
                    w_stopNext     = cmd_stop;
                    w_fromHoldNext = (r_state == S_HOLD);
                    w_quarterNext  = 2'd0;
                    w_bitIdxNext   = 3'd7;
                    w_stateNext    = cmd_start ? S_START : S_DATA;
                end
            end
            S_START: begin
                if (w_tick && r_quarter == 2'd3) begin
                    w_stateNext = S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && r_quarter == 2'd3) begin
                    w_bitIdxNext = r_bitIdx - 3'd1;
                    if (r_bitIdx == 3'd0) begin
                        w_stateNext = S_ACK;
                    end
                end
            end
            S_ACK: begin
                if (w_tick && r_quarter == 2'd2) begin
                    w_ackSampleNext = r_sdaSync[1];
                end
                if (w_tick && r_quarter == 2'd3) begin
                    if (r_stop) begin
                        w_stateNext = S_STOP;
                    end else begin
                        w_stateNext = S_HOLD;
                        w_doneNext  = 1'b1;
                        w_nackNext  = r_ackSample;
                    end
                end
            end
            S_STOP: begin
                if (w_tick && r_quarter == 2'd3) begin
                    w_stateNext = S_IDLE;
                    w_doneNext  = 1'b1;
                    w_nackNext  = r_ackSample;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
            end
        endcase
    end

    // Line drive decode: a repeated START keeps SCL low in q0 because HOLD left it low.
    always_comb begin
        w_sclLow = 1'b0;
        w_sdaLow = 1'b0;
        case (r_state)
            S_START: begin
                w_sclLow = (r_quarter == 2'd3) || (r_quarter == 2'd0 && r_fromHold);
                w_sdaLow = r_quarter[1];
            end
            S_DATA: begin
                w_sclLow = (r_quarter == 2'd0) || (r_quarter == 2'd3);
                w_sdaLow = !r_data[r_bitIdx];
            end
            S_ACK: begin
                w_sclLow = (r_quarter == 2'd0) || (r_quarter == 2'd3);
            end
            S_STOP: begin
                w_sclLow = (r_quarter == 2'd0);
                w_sdaLow = !r_quarter[1];
            end
            S_HOLD: begin
                w_sclLow = 1'b1;
            end
            default: begin
                w_sclLow = 1'b0;
                w_sdaLow = 1'b0;
            end
        endcase
    end

endmodule
